ahb_decoder_mux: RTL and testbench

AHB_DECODER_MUX -- requirements
Module: ahb_decoder_mux

---
 rtl/ahb_map_pkg.sv | 10 +
 rtl/common_types_pkg.sv | 20 ++
 rtl/ahb_bus_if.sv | 25 ++
 rtl/ahb_default_slave.sv | 90 +++++++++
 rtl/ahb_decoder_mux.sv | 124 ++++++++++++
 tb/tb_ahb_decoder_mux.sv | 333 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ahb_map_pkg.sv
// Default system address map: slave 0 at 0x0000_0000 (64 KiB), slave 1 at 0x4000_0000 (4 KiB).
package ahb_map_pkg;

  localparam int MAP_NSLV = 2;

  // Index 0 sits in the least significant 32 bits.
  localparam logic [MAP_NSLV*32-1:0] MAP_SLV_BASE = {32'h4000_0000, 32'h0000_0000};
  localparam logic [MAP_NSLV*32-1:0] MAP_SLV_MASK = {32'hFFFF_F000, 32'hFFFF_0000};

endpackage

// File: rtl/common_types_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package common_types_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

endpackage

// File: rtl/ahb_bus_if.sv
// Master-side AHB-Lite bundle: address/control/write data out, read data/response back.
interface ahb_bus_if;
  import common_types_pkg::*;

  logic [31:0] haddr;
  logic [31:0] hwdata;
  htrans_t     htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, hwdata, htrans, hsize, hburst, hwrite,
    input  hrdata, hready, hresp
  );

  modport mux_to_master (
    input  haddr, hwdata, htrans, hsize, hburst, hwrite,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers plus sticky error capture.
module ahb_default_slave
  import common_types_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                accept_i,
  input  logic [31:0]         addr_i,
  input  logic                err_clr_i,
  output logic                hready_o,
  output logic                hresp_o,
  output logic                err_valid_o,
  output logic [31:0]         err_addr_o,
  output logic [ERRCNT_W-1:0] err_count_o
);

  ds_state_t             state_q, state_d;
  logic                  err_enter;
  logic                  err_valid_q, err_valid_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // No accept can arrive in DS_ERR1 because the muxed hready is held low there.
  always_comb begin
    state_d  = state_q;
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    unique case (state_q)
      DS_IDLE: begin
        if (accept_i) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = HRESP_ERROR;
        state_d = accept_i ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  assign err_enter = (state_d == DS_ERR1);

  // Clearing first lets a coincident new error overwrite the cleared state.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end
    if (err_enter) begin
      if (!err_valid_d) err_addr_d = addr_i;
      err_valid_d = 1'b1;
      if (err_count_d != '1) err_count_d = err_count_d + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_count_o = err_count_q;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer for NSLV slaves, with an
// internal default slave answering accesses that hit no slave.
module ahb_decoder_mux
  import common_types_pkg::*;
#(
  parameter int                 NSLV     = ahb_map_pkg::MAP_NSLV,
  parameter logic [NSLV*32-1:0] SLV_BASE = ahb_map_pkg::MAP_SLV_BASE,
  parameter logic [NSLV*32-1:0] SLV_MASK = ahb_map_pkg::MAP_SLV_MASK,
  parameter int                 ERRCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  ahb_bus_if.mux_to_master      m_if,
  output logic [NSLV-1:0]       s_hsel,
  output logic [NSLV-1:0]       s_hready,
  output logic [31:0]           s_haddr,
  output logic [31:0]           s_hwdata,
  output logic [1:0]            s_htrans,
  output logic [2:0]            s_hsize,
  output logic [2:0]            s_hburst,
  output logic                  s_hwrite,
  input  logic [NSLV-1:0][31:0] s_hrdata,
  input  logic [NSLV-1:0]       s_hreadyout,
  input  logic [NSLV-1:0]       s_hresp,
  output logic                  err_valid,
  output logic [31:0]           err_addr,
  output logic [ERRCNT_W-1:0]   err_count,
  input  logic                  err_clr
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic             addr_active;
  logic             addr_hit;
  logic [IDX_W-1:0] addr_idx;
  logic             sel_def_q, sel_def_d;
  logic             sel_act_q, sel_act_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic             hready_mux;
  logic             hresp_mux;
  logic [31:0]      hrdata_mux;
  logic             ds_accept;
  logic             ds_hready;
  logic             ds_hresp;

  assign addr_active = (m_if.htrans == HTRANS_NONSEQ) || (m_if.htrans == HTRANS_SEQ);

  // Scanning downwards makes the lowest matching index the final winner.
  always_comb begin
    addr_hit = 1'b0;
    addr_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_if.haddr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        addr_hit = 1'b1;
        addr_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    s_hsel = '0;
    if (addr_active && addr_hit) s_hsel[addr_idx] = 1'b1;
  end

  assign sel_idx_d = addr_idx;
  assign sel_def_d = !addr_hit;
  assign sel_act_d = addr_active;

  // The data-phase target only advances when the current data phase completes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sel_idx_q <= '0;
      sel_def_q <= 1'b1;
      sel_act_q <= 1'b0;
    end else if (hready_mux) begin
      sel_idx_q <= sel_idx_d;
      sel_def_q <= sel_def_d;
      sel_act_q <= sel_act_d;
    end
  end

  always_comb begin
    hready_mux = 1'b1;
    hresp_mux  = HRESP_OKAY;
    hrdata_mux = '0;
    if (sel_act_q && sel_def_q) begin
      hready_mux = ds_hready;
      hresp_mux  = ds_hresp;
    end else if (sel_act_q) begin
      hready_mux = s_hreadyout[sel_idx_q];
      hresp_mux  = s_hresp[sel_idx_q];
      hrdata_mux = s_hrdata[sel_idx_q];
    end
  end

  assign ds_accept = hready_mux && addr_active && !addr_hit;

  ahb_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_default_slave (
    .clk         (clk),
    .nrst        (nrst),
    .accept_i    (ds_accept),
    .addr_i      (m_if.haddr),
    .err_clr_i   (err_clr),
    .hready_o    (ds_hready),
    .hresp_o     (ds_hresp),
    .err_valid_o (err_valid),
    .err_addr_o  (err_addr),
    .err_count_o (err_count)
  );

  assign m_if.hready = hready_mux;
  assign m_if.hresp  = hresp_mux;
  assign m_if.hrdata = hrdata_mux;
  assign s_hready    = {NSLV{hready_mux}};
  assign s_haddr     = m_if.haddr;
  assign s_hwdata    = m_if.hwdata;
  assign s_htrans    = m_if.htrans;
  assign s_hsize     = m_if.hsize;
  assign s_hburst    = m_if.hburst;
  assign s_hwrite    = m_if.hwrite;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: two modelled slaves, a pipelined master and
// a queue of expected data-phase results.
module tb_ahb_decoder_mux;
  import common_types_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    logic        chkData;
    int          waits;
    int          id;
  } exp_t;

  logic             clk = 1'b0;
  logic             nrst;
  logic [1:0]       s_hsel, s_hready;
  logic [31:0]      s_haddr, s_hwdata;
  logic [1:0]       s_htrans;
  logic [2:0]       s_hsize, s_hburst;
  logic             s_hwrite;
  logic [1:0][31:0] s_hrdata;
  logic [1:0]       s_hreadyout, s_hresp;
  logic             err_valid;
  logic [31:0]      err_addr;
  logic [7:0]       err_count;
  logic             err_clr;

  ahb_bus_if m ();

  ahb_decoder_mux #(
    .NSLV     (2),
    .ERRCNT_W (8)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .m_if        (m),
    .s_hsel      (s_hsel),
    .s_hready    (s_hready),
    .s_haddr     (s_haddr),
    .s_hwdata    (s_hwdata),
    .s_htrans    (s_htrans),
    .s_hsize     (s_hsize),
    .s_hburst    (s_hburst),
    .s_hwrite    (s_hwrite),
    .s_hrdata    (s_hrdata),
    .s_hreadyout (s_hreadyout),
    .s_hresp     (s_hresp),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_count   (err_count),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Slave models: configurable wait states and read data, always OKAY.
  int          waitCfg [2];
  logic [31:0] rdataCfg [2];
  int          slvWait [2];
  logic [1:0]  slvAct, slvRead;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slvAct  <= '0;
      slvRead <= '0;
      for (int i = 0; i < 2; i++) slvWait[i] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_hready[i]) begin
          slvAct[i]  <= s_hsel[i];
          slvRead[i] <= !s_hwrite;
          slvWait[i] <= waitCfg[i];
        end else if (slvAct[i] && slvWait[i] > 0) begin
          slvWait[i] <= slvWait[i] - 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      s_hreadyout[i] = !(slvAct[i] && slvWait[i] != 0);
      s_hresp[i]     = 1'b0;
      s_hrdata[i]    = (slvAct[i] && slvRead[i]) ? rdataCfg[i] : 32'h0;
    end
  end

  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];
  logic        dphActive = 1'b0;
  logic        lastAccepted = 1'b0;
  logic        addrChkPending = 1'b0;
  int          waitSeen = 0;
  int          nextId = 0;
  logic        mValid = 1'b0;
  logic [31:0] mAddr = '0;
  logic [7:0]  mCount = '0;

  // Reference decode of the default map.
  function automatic logic [1:0] expSel(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 2'b01;
    if ((a & 32'hFFFF_F000) == 32'h4000_0000) return 2'b10;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score data phase, update error model, return at posedge+1.
  task automatic tick();
    exp_t e;
    logic rdy, clrS, accUnm;
    @(negedge clk);
    rdy  = m.hready;
    clrS = err_clr;
    if (addrChkPending) begin
      checkOutput($sformatf("hsel#%0d", nextId - 1), {30'd0, s_hsel}, {30'd0, expSel(m.haddr)});
      checkOutput($sformatf("haddr#%0d", nextId - 1), s_haddr, m.haddr);
      addrChkPending = 1'b0;
    end
    if (dphActive) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL scoreboard: observed 0 entries expected 1");
        dphActive = 1'b0;
      end else begin
        e = sb[0];
        if (rdy !== 1'b1) begin
          waitSeen++;
          if (e.resp) checkOutput($sformatf("waitresp#%0d", e.id), {31'd0, m.hresp}, 32'd1);
        end else begin
          void'(sb.pop_front());
          checkOutput($sformatf("waits#%0d", e.id), waitSeen, e.waits);
          checkOutput($sformatf("hresp#%0d", e.id), {31'd0, m.hresp}, {31'd0, e.resp});
          if (e.chkData) checkOutput($sformatf("hrdata#%0d", e.id), m.hrdata, e.rdata);
          dphActive = 1'b0;
        end
      end
    end
    lastAccepted = (rdy === 1'b1) && (m.htrans == HTRANS_NONSEQ);
    accUnm = lastAccepted && (expSel(m.haddr) == 2'b00);
    if (clrS === 1'b1) begin
      mValid = 1'b0;
      mAddr  = '0;
      mCount = '0;
    end
    if (accUnm) begin
      if (!mValid) mAddr = m.haddr;
      mValid = 1'b1;
      if (mCount != 8'hFF) mCount = mCount + 8'd1;
    end
    if (lastAccepted) begin
      dphActive = 1'b1;
      waitSeen  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] rdata,
                               input logic chkData, input int waits, input logic resp);
    exp_t e;
    m.haddr  = addr;
    m.hwrite = wr;
    m.htrans = HTRANS_NONSEQ;
    e = '{rdata: rdata, resp: resp, chkData: chkData, waits: waits, id: nextId};
    sb.push_back(e);
    nextId++;
    addrChkPending = 1'b1;
    lastAccepted   = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (lastAccepted) break;
    end
    if (!lastAccepted) begin
      checks++;
      errors++;
      $error("[TB] FAIL accept#%0d: observed pending expected accepted within 20 cycles", e.id);
    end
    m.hwdata = addr ^ 32'h5A5A_A5A5;
  endtask

  task automatic drain();
    m.htrans = HTRANS_IDLE;
    for (int n = 0; n < 20; n++) begin
      if (!dphActive) break;
      tick();
    end
    if (dphActive) begin
      checks++;
      errors++;
      $error("[TB] FAIL drain: observed data phase still open expected closed within 20 cycles");
    end
  endtask

  task automatic checkErr(input string tag);
    checkOutput({tag, "-valid"}, {31'd0, err_valid}, {31'd0, mValid});
    checkOutput({tag, "-addr"}, err_addr, mAddr);
    checkOutput({tag, "-count"}, {24'd0, err_count}, {24'd0, mCount});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed time limit expected normal end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst        = 1'b0;
    err_clr     = 1'b0;
    m.haddr     = '0;
    m.hwdata    = '0;
    m.htrans    = HTRANS_IDLE;
    m.hsize     = 3'b010;
    m.hburst    = 3'b000;
    m.hwrite    = 1'b0;
    waitCfg[0]  = 0;
    waitCfg[1]  = 0;
    rdataCfg[0] = 32'h0;
    rdataCfg[1] = 32'h0;

    // Values held during reset.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst-hready", {31'd0, m.hready}, 32'd1);
    checkOutput("rst-hresp", {31'd0, m.hresp}, 32'd0);
    checkOutput("rst-shready", {30'd0, s_hready}, 32'd3);
    checkErr("rst");
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] idle and busy transfers do not select");
    m.haddr  = 32'h0000_0100;
    m.htrans = HTRANS_IDLE;
    #1;
    checkOutput("idle-hsel", {30'd0, s_hsel}, 32'd0);
    m.htrans = HTRANS_BUSY;
    #1;
    checkOutput("busy-hsel", {30'd0, s_hsel}, 32'd0);
    m.htrans = HTRANS_IDLE;
    tick();

    $display("[TB] read with one wait state");
    rdataCfg[0] = 32'hDEAD_BEEF;
    waitCfg[0]  = 1;
    applyStimulus(32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
    drain();

    $display("[TB] back-to-back write slave 1 then read slave 0");
    waitCfg[0]  = 0;
    rdataCfg[0] = 32'h1234_5678;
    rdataCfg[1] = 32'hCAFE_F00D;
    applyStimulus(32'h4000_0004, 1'b1, 32'h0, 1'b0, 0, 1'b0);
    applyStimulus(32'h0000_0008, 1'b0, 32'h1234_5678, 1'b1, 0, 1'b0);
    drain();

    $display("[TB] slave 1 stalls with two wait states");
    waitCfg[1] = 2;
    applyStimulus(32'h4000_0010, 1'b0, 32'hCAFE_F00D, 1'b1, 2, 1'b0);
    applyStimulus(32'h0000_0020, 1'b0, 32'h1234_5678, 1'b1, 0, 1'b0);
    drain();
    waitCfg[1] = 0;

    $display("[TB] single unmapped access");
    applyStimulus(32'h8000_0000, 1'b0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    checkErr("err1");

    $display("[TB] error clear without new error");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkErr("clr");

    $display("[TB] three back-to-back unmapped accesses");
    applyStimulus(32'h9000_0000, 1'b0, 32'h0, 1'b1, 1, 1'b1);
    applyStimulus(32'hA000_0010, 1'b1, 32'h0, 1'b0, 1, 1'b1);
    applyStimulus(32'hFFFF_FFF0, 1'b0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    checkErr("err3");

    $display("[TB] error counter saturation");
    for (int k = 0; k < 256; k++) begin
      applyStimulus(32'h8000_0000 + 32'(k * 16), 1'b0, 32'h0, 1'b1, 1, 1'b1);
    end
    drain();
    checkErr("sat");

    $display("[TB] clear coincident with a new error");
    err_clr = 1'b1;
    applyStimulus(32'hC000_0000, 1'b0, 32'h0, 1'b1, 1, 1'b1);
    err_clr = 1'b0;
    drain();
    checkErr("clrnew");

    $display("[TB] reset during error response");
    applyStimulus(32'hB000_0000, 1'b0, 32'h0, 1'b1, 1, 1'b1);
    m.htrans = HTRANS_IDLE;
    #1;
    checkOutput("err1-hready", {31'd0, m.hready}, 32'd0);
    nrst = 1'b0;
    #1;
    checkOutput("midrst-hready", {31'd0, m.hready}, 32'd1);
    checkOutput("midrst-hresp", {31'd0, m.hresp}, 32'd0);
    sb.delete();
    dphActive = 1'b0;
    waitSeen  = 0;
    mValid    = 1'b0;
    mAddr     = '0;
    mCount    = '0;
    checkErr("midrst");
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_0000, 1'b0, 32'h1234_5678, 1'b1, 0, 1'b0);
    drain();
    checkErr("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
